// File: rtl/write_drain_ctrl.sv
// ---------------------------------------------------------------------------
// write_drain_ctrl
//
// Drains the cache write FIFO onto an AXI master write port. The block pops
// one entry, issues a single-beat AW/W pair, waits for the B response and
// checks it. Only one write is outstanding at a time. It also keeps sticky
// error flags and a wrapping count of completed writes.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   enable                 allows new pops from IDLE (an in-flight write
//                          always completes)
//   fifo_empty             the write FIFO has nothing to pop
//   fifo_pop_valid/ready   pop handshake (fifo_pop_valid is combinational)
//   fifo_pop_data          entry {addr,id,burst,size,len,data,strb}; it is
//                          valid the cycle after the pop handshake
//   m_aw*                  AW channel (m_awlen is always 0: one beat)
//   m_w*                   W channel (m_wlast equals m_wvalid)
//   m_b*                   B channel
//   busy                   controller not in IDLE
//   err[3:0]               sticky: [0] BRESP!=OKAY, [1] BID mismatch,
//                          [2] entry len!=0, [3] B response timeout
//   err_clr                clears err; a set in the same cycle wins
//   done_cnt               completed writes, wraps at 2^16
// ---------------------------------------------------------------------------
module write_drain_ctrl #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 64,
  parameter  int ID_WIDTH   = 4,
  parameter  int TIMEOUT    = 1024,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int WIDTH      = ADDR_WIDTH + ID_WIDTH + 2 + 3 + 8 + DATA_WIDTH + STRB_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  // write FIFO pop port
  input  logic                  fifo_empty,
  output logic                  fifo_pop_valid,
  input  logic                  fifo_pop_ready,
  input  logic [WIDTH-1:0]      fifo_pop_data,
  // AXI write address channel
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [ID_WIDTH-1:0]   m_awid,
  output logic [1:0]            m_awburst,
  output logic [2:0]            m_awsize,
  output logic [7:0]            m_awlen,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  // AXI write data channel
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  // AXI write response channel
  input  logic [ID_WIDTH-1:0]   m_bid,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  // status
  output logic                  busy,
  output logic [3:0]            err,
  input  logic                  err_clr,
  output logic [15:0]           done_cnt
);

  // Bit positions of the entry fields, counted from the LSB end.
  localparam int STRB_LSB  = 0;
  localparam int DATA_LSB  = STRB_LSB + STRB_WIDTH;
  localparam int LEN_LSB   = DATA_LSB + DATA_WIDTH;
  localparam int SIZE_LSB  = LEN_LSB + 8;
  localparam int BURST_LSB = SIZE_LSB + 3;
  localparam int ID_LSB    = BURST_LSB + 2;
  localparam int ADDR_LSB  = ID_LSB + ID_WIDTH;

  // The timeout counter has to hold TIMEOUT itself, where it saturates.
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TOUT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state, state_next;

  // Registered outputs and payload
  logic                  awvalid_reg, awvalid_next;
  logic                  wvalid_reg,  wvalid_next;
  logic                  bready_reg,  bready_next;
  logic                  busy_reg,    busy_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ID_WIDTH-1:0]   id_reg;
  logic [1:0]            burst_reg;
  logic [2:0]            size_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [STRB_WIDTH-1:0] strb_reg;
  logic [3:0]            err_reg,  err_next;
  logic [15:0]           done_reg, done_next;
  logic [CNT_W-1:0]      tout_cnt_reg, tout_cnt_next;

  // Decode helpers
  logic       pop_hs;
  logic       aw_finished;
  logic       w_finished;
  logic       load_payload;
  logic [3:0] err_set;
  logic [7:0] entry_len;

  assign entry_len = fifo_pop_data[LEN_LSB +: 8];

  // Pop requests only come from IDLE; this is the one unregistered output.
  assign fifo_pop_valid = (state == S_IDLE) && enable && !fifo_empty;
  assign pop_hs         = fifo_pop_valid && fifo_pop_ready;

  // A channel is finished once its valid has dropped or it handshakes now.
  // The two channels are tracked independently through their valid bits.
  assign aw_finished = !awvalid_reg || m_awready;
  assign w_finished  = !wvalid_reg  || m_wready;

  // -------------------------------------------------------------------------
  // FSM process 1: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pop_hs) state_next = S_LOAD;
      S_LOAD:  state_next = S_ISSUE;
      S_ISSUE: if (aw_finished && w_finished) state_next = S_RESP;
      S_RESP:  if (m_bvalid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: output / datapath control. Everything here feeds a
  // register, so all AXI outputs come straight from flops.
  // -------------------------------------------------------------------------
  always_comb begin
    awvalid_next  = 1'b0;
    wvalid_next   = 1'b0;
    load_payload  = 1'b0;
    err_set       = 4'b0000;
    done_next     = done_reg;
    tout_cnt_next = '0;

    // bready is high for exactly the cycles spent in RESP.
    bready_next = (state_next == S_RESP);
    busy_next   = (state_next != S_IDLE);

    case (state)
      S_LOAD: begin
        load_payload = 1'b1;
        awvalid_next = 1'b1;
        wvalid_next  = 1'b1;
        // Only single-beat writes are issued; a burst entry is flagged.
        err_set[2]   = (entry_len != 8'd0);
      end
      S_ISSUE: begin
        awvalid_next = awvalid_reg && !m_awready;
        wvalid_next  = wvalid_reg  && !m_wready;
      end
      S_RESP: begin
        if (m_bvalid) begin
          err_set[0] = (m_bresp != 2'b00);
          err_set[1] = (m_bid != id_reg);
          done_next  = done_reg + 16'd1;
        end else begin
          // Count cycles without a response. The flag is raised once, on
          // the cycle the counter reaches TIMEOUT; the write then keeps
          // waiting and can still complete normally.
          if (tout_cnt_reg != TOUT_MAX) begin
            tout_cnt_next = tout_cnt_reg + CNT_ONE;
          end else begin
            tout_cnt_next = tout_cnt_reg;
          end
          err_set[3] = (tout_cnt_reg == TOUT_MAX - CNT_ONE);
        end
      end
      default: begin
      end
    endcase

    // A set in the same cycle as the clear takes priority.
    err_next = (err_clr ? 4'b0000 : err_reg) | err_set;
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid_reg  <= 1'b0;
      wvalid_reg   <= 1'b0;
      bready_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 4'b0000;
      done_reg     <= 16'd0;
      tout_cnt_reg <= '0;
    end else begin
      awvalid_reg  <= awvalid_next;
      wvalid_reg   <= wvalid_next;
      bready_reg   <= bready_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
      done_reg     <= done_next;
      tout_cnt_reg <= tout_cnt_next;
    end
  end

  // The payload is only written in LOAD, so it stays stable for the whole
  // time either valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      id_reg    <= '0;
      burst_reg <= '0;
      size_reg  <= '0;
      data_reg  <= '0;
      strb_reg  <= '0;
    end else if (load_payload) begin
      addr_reg  <= fifo_pop_data[ADDR_LSB  +: ADDR_WIDTH];
      id_reg    <= fifo_pop_data[ID_LSB    +: ID_WIDTH];
      burst_reg <= fifo_pop_data[BURST_LSB +: 2];
      size_reg  <= fifo_pop_data[SIZE_LSB  +: 3];
      data_reg  <= fifo_pop_data[DATA_LSB  +: DATA_WIDTH];
      strb_reg  <= fifo_pop_data[STRB_LSB  +: STRB_WIDTH];
    end
  end

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign m_awaddr  = addr_reg;
  assign m_awid    = id_reg;
  assign m_awburst = burst_reg;
  assign m_awsize  = size_reg;
  assign m_awlen   = 8'd0;
  assign m_awvalid = awvalid_reg;

  assign m_wdata   = data_reg;
  assign m_wstrb   = strb_reg;
  assign m_wlast   = wvalid_reg;
  assign m_wvalid  = wvalid_reg;

  assign m_bready  = bready_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;
  assign done_cnt  = done_reg;

  // -------------------------------------------------------------------------
  // Protocol properties
  // -------------------------------------------------------------------------
  a_aw_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_awvalid && !m_awready) |=> (m_awvalid && $stable(m_awaddr) && $stable(m_awid)));

  a_w_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_wvalid && !m_wready) |=> (m_wvalid && $stable(m_wdata) && $stable(m_wstrb)));

  a_single_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    m_bready |-> (!m_awvalid && !m_wvalid && !fifo_pop_valid));

endmodule

// File: tb/tb_write_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_write_drain_ctrl
//
// Directed bench for write_drain_ctrl. A small array acts as the write
// FIFO; the AXI slave side (readies, B response) is driven step by step from
// the main sequence so each handshake lands on a known cycle.
// ---------------------------------------------------------------------------
module tb_write_drain_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int IW    = 4;
  localparam int SW    = DW / 8;
  localparam int TOUT  = 16;
  localparam int WIDTH = AW + IW + 2 + 3 + 8 + DW + SW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             fifo_empty;
  logic             fifo_pop_valid;
  logic             fifo_pop_ready;
  logic [WIDTH-1:0] fifo_pop_data;
  logic [AW-1:0]    m_awaddr;
  logic [IW-1:0]    m_awid;
  logic [1:0]       m_awburst;
  logic [2:0]       m_awsize;
  logic [7:0]       m_awlen;
  logic             m_awvalid;
  logic             m_awready;
  logic [DW-1:0]    m_wdata;
  logic [SW-1:0]    m_wstrb;
  logic             m_wlast;
  logic             m_wvalid;
  logic             m_wready;
  logic [IW-1:0]    m_bid;
  logic [1:0]       m_bresp;
  logic             m_bvalid;
  logic             m_bready;
  logic             busy;
  logic [3:0]       err;
  logic             err_clr;
  logic [15:0]      done_cnt;

  always #5 clk = ~clk;

  write_drain_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .TIMEOUT    (TOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_pop_valid (fifo_pop_valid),
    .fifo_pop_ready (fifo_pop_ready),
    .fifo_pop_data  (fifo_pop_data),
    .m_awaddr       (m_awaddr),
    .m_awid         (m_awid),
    .m_awburst      (m_awburst),
    .m_awsize       (m_awsize),
    .m_awlen        (m_awlen),
    .m_awvalid      (m_awvalid),
    .m_awready      (m_awready),
    .m_wdata        (m_wdata),
    .m_wstrb        (m_wstrb),
    .m_wlast        (m_wlast),
    .m_wvalid       (m_wvalid),
    .m_wready       (m_wready),
    .m_bid          (m_bid),
    .m_bresp        (m_bresp),
    .m_bvalid       (m_bvalid),
    .m_bready       (m_bready),
    .busy           (busy),
    .err            (err),
    .err_clr        (err_clr),
    .done_cnt       (done_cnt)
  );

  // ---------------- FIFO model: data appears the cycle after the pop -------
  logic [WIDTH-1:0] fq [0:31];
  int               wr_ptr = 0;
  int               rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_pop_valid && fifo_pop_ready) begin
      fifo_pop_data <= fq[rd_ptr % 32];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // ---------------- checking -----------------------------------------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_done;
  logic [3:0]  exp_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                      input logic [7:0] len, input logic [DW-1:0] data,
                      input logic [SW-1:0] strb);
    fq[wr_ptr % 32] = {addr, id, 2'b01, 3'b011, len, data, strb};
    wr_ptr++;
  endtask

  // One complete write. aw_dly/w_dly: ISSUE cycles before that ready rises;
  // b_dly: RESP cycles before bvalid. clr_load pulses err_clr during LOAD.
  task automatic do_write(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                          input logic [7:0] len, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [IW-1:0] bid, input logic [1:0] bresp,
                          input bit clr_load, input bit do_push);
    bit aw_done;
    bit w_done;
    bit aw_hs;
    bit w_hs;
    int k;
    if (do_push) push(addr, id, len, data, strb);
    enable         = 1'b1;
    fifo_pop_ready = 1'b1;
    #1;
    k = 0;
    while (!fifo_pop_valid && k < 20) begin
      step();
      k++;
    end
    check("pop_valid", fifo_pop_valid, 1);
    step();                                   // LOAD (T+1)
    check("load_busy", busy, 1);
    check("load_awvalid", m_awvalid, 0);
    check("load_pop_valid", fifo_pop_valid, 0);
    if (clr_load) begin
      err_clr = 1'b1;
      exp_err = 4'b0000;
    end
    if (len != 8'd0) exp_err[2] = 1'b1;
    step();                                   // first ISSUE cycle (T+2)
    err_clr = 1'b0;
    check("issue_err", err, exp_err);
    aw_done = 0;
    w_done  = 0;
    k = 0;
    while (!(aw_done && w_done) && k < 40) begin
      check("awvalid", m_awvalid, !aw_done);
      check("wvalid", m_wvalid, !w_done);
      check("wlast", m_wlast, !w_done);
      check("issue_bready", m_bready, 0);
      if (!aw_done) begin
        check("awaddr", m_awaddr, addr);
        check("awid", m_awid, id);
        check("awlen", m_awlen, 0);
        check("awburst", m_awburst, 2'b01);
        check("awsize", m_awsize, 3'b011);
      end
      if (!w_done) begin
        check("wdata", m_wdata, data);
        check("wstrb", m_wstrb, strb);
      end
      aw_hs     = !aw_done && (k >= aw_dly);
      w_hs      = !w_done  && (k >= w_dly);
      m_awready = (k >= aw_dly);
      m_wready  = (k >= w_dly);
      step();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      k++;
    end
    m_awready = 1'b0;
    m_wready  = 1'b0;
    check("resp_awvalid", m_awvalid, 0);
    check("resp_wvalid", m_wvalid, 0);
    for (int j = 0; j < b_dly; j++) begin
      check("resp_bready", m_bready, 1);
      if (j == TOUT - 1) check("tout_before", err[3], exp_err[3]);
      if (j == TOUT)     check("tout_after", err[3], 1);
      step();
    end
    check("b_bready", m_bready, 1);
    m_bvalid = 1'b1;
    m_bid    = bid;
    m_bresp  = bresp;
    step();                                   // back in IDLE
    m_bvalid = 1'b0;
    exp_done = exp_done + 16'd1;
    if (bresp != 2'b00) exp_err[0] = 1'b1;
    if (bid != id)      exp_err[1] = 1'b1;
    if (b_dly >= TOUT)  exp_err[3] = 1'b1;
    check("end_bready", m_bready, 0);
    check("end_busy", busy, 0);
    check("end_done_cnt", done_cnt, exp_done);
    check("end_err", err, exp_err);
    $display("write addr=0x%0h id=%0d len=%0d done_cnt=%0d err=%b", addr, id, len, done_cnt, err);
  endtask

  // ---------------- sequence ------------------------------------------------
  initial begin
    int k;
    rst_n          = 1'b0;
    enable         = 1'b0;
    fifo_pop_ready = 1'b0;
    m_awready      = 1'b0;
    m_wready       = 1'b0;
    m_bid          = '0;
    m_bresp        = 2'b00;
    m_bvalid       = 1'b0;
    err_clr        = 1'b0;
    exp_done       = 16'd0;
    exp_err        = 4'b0000;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_awvalid", m_awvalid, 0);
    check("rst_wvalid", m_wvalid, 0);
    check("rst_bready", m_bready, 0);
    check("rst_err", err, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_pop_valid", fifo_pop_valid, 0);
    rst_n = 1'b1;
    step();

    // Single write, all ready at the first opportunity.
    do_write(32'h0000_1000, 4'd3, 8'd0, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, 0, 0, 4'd3, 2'b00, 0, 1);
    check("single_done", done_cnt, 16'd1);
    check("single_err", err, 4'b0000);

    // Skewed handshakes: awready after 5 cycles, wready after 1.
    do_write(32'h0000_2040, 4'd6, 8'd0, 64'h0123_4567_89AB_CDEF, 8'h0F, 5, 1, 2, 4'd6, 2'b00, 0, 1);
    check("skew_done", done_cnt, 16'd2);

    // Error responses.
    do_write(32'h0000_3000, 4'd3, 8'd0, 64'h1111_2222_3333_4444, 8'hF0, 0, 0, 0, 4'd3, 2'b10, 0, 1);
    check("bresp_err", err, 4'b0001);
    do_write(32'h0000_3008, 4'd3, 8'd0, 64'h5555_6666_7777_8888, 8'h3C, 0, 0, 1, 4'd5, 2'b00, 0, 1);
    check("bid_err", err, 4'b0011);

    // len=4 entry with err_clr in the same cycle as the len flag is set.
    do_write(32'h0000_4000, 4'd9, 8'd4, 64'h9999_AAAA_BBBB_CCCC, 8'h01, 1, 0, 0, 4'd9, 2'b00, 1, 1);
    check("len_clr_err", err, 4'b0100);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    exp_err = 4'b0000;
    check("clr_err", err, 4'b0000);

    // Timeout: bvalid withheld 20 cycles of RESP.
    do_write(32'h0000_5000, 4'd2, 8'd0, 64'h0F0F_0F0F_F0F0_F0F0, 8'hAA, 0, 0, 20, 4'd2, 2'b00, 0, 1);
    check("tout_err", err, 4'b1000);
    check("tout_done", done_cnt, 16'd6);

    // enable low with a non-empty FIFO: nothing is popped.
    enable = 1'b0;
    push(32'h0000_6000, 4'd7, 8'd0, 64'h0000_0000_0000_0006, 8'h55);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("dis_pop_valid", fifo_pop_valid, 0);
      check("dis_busy", busy, 0);
      step();
    end
    do_write(32'h0000_6000, 4'd7, 8'd0, 64'h0000_0000_0000_0006, 8'h55, 0, 0, 0, 4'd7, 2'b00, 0, 0);

    // Reset while the write is stuck in ISSUE.
    push(32'h0000_7000, 4'd1, 8'd0, 64'h7777_7777_7777_7777, 8'hFF);
    enable = 1'b1;
    #1;
    k = 0;
    while (!m_awvalid && k < 10) begin
      step();
      k++;
    end
    check("pre_rst_awvalid", m_awvalid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_awvalid", m_awvalid, 0);
    check("mid_rst_wvalid", m_wvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_done", done_cnt, 0);
    check("mid_rst_awaddr", m_awaddr, 0);
    check("mid_rst_wdata", m_wdata, 0);
    check("mid_rst_pop_valid", fifo_pop_valid, 0);
    step();
    rst_n    = 1'b1;
    exp_done = 16'd0;
    exp_err  = 4'b0000;
    step();
    check("post_rst_busy", busy, 0);
    $display("reset during ISSUE: busy=%0d done_cnt=%0d", busy, done_cnt);

    // Ten back-to-back entries.
    for (int i = 0; i < 10; i++) begin
      push(32'h0000_8000 + 32'(i * 8), 4'(i), 8'd0, 64'(i) * 64'h0101_0101_0101_0101, 8'hFF);
    end
    for (int i = 0; i < 10; i++) begin
      do_write(32'h0000_8000 + 32'(i * 8), 4'(i), 8'd0, 64'(i) * 64'h0101_0101_0101_0101, 8'hFF,
               0, 0, 0, 4'(i), 2'b00, 0, 0);
    end
    check("b2b_done", done_cnt, 16'd10);
    check("b2b_err", err, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
